// File: rtl/multicycle_controller_pkg.sv
// Shared CPU types for the multicycle controller (the CPUType package):
// opcode/funct field types, their decoded constants and the controller
// state encoding. The JUMP state exists only when ASTRIO_JUMP_EN is defined.
package multicycle_controller_pkg;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;

  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_J     = 6'h02;
  localparam opcode_t OP_BEQ   = 6'h04;
  localparam opcode_t OP_BNE   = 6'h05;
  localparam opcode_t OP_ADDI  = 6'h08;
  localparam opcode_t OP_SLTI  = 6'h0A;
  localparam opcode_t OP_ANDI  = 6'h0C;
  localparam opcode_t OP_ORI   = 6'h0D;
  localparam opcode_t OP_LW    = 6'h23;
  localparam opcode_t OP_SW    = 6'h2B;

  localparam funct_t FN_SLL = 6'h00;
  localparam funct_t FN_SRL = 6'h02;
  localparam funct_t FN_ADD = 6'h20;
  localparam funct_t FN_SUB = 6'h22;
  localparam funct_t FN_AND = 6'h24;
  localparam funct_t FN_OR  = 6'h25;
  localparam funct_t FN_SLT = 6'h2A;

  // Fixed encodings so the debug state output means the same in every build.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
`ifdef ASTRIO_JUMP_EN
    JUMP     = 4'd11,
`endif
    TRAP     = 4'd12
  } ctrl_state_t;

  // R-type function codes the ALU supports; anything else is illegal.
  function automatic logic is_rtype_funct(input funct_t f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL, FN_SRL, FN_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Immediate-operand ALU instructions.
  function automatic logic is_alu_imm(input opcode_t op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles of the current access. expired is high while
// the count equals limit; the caller decides whether that is a bus error
// (a ready in the same cycle still wins).
module mem_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       count,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] wait_cnt;

  // Clear between accesses, count stalled cycles, saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (clear) begin
      wait_cnt <= 8'd0;
    end else if (count && (wait_cnt != 8'hFF)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign expired = (wait_cnt == limit);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM. Moore outputs decode from the state register;
// pc_write and ir_write additionally follow mem_ready/zero where the
// transfer completes. Define ASTRIO_JUMP_EN to add the JUMP state for
// opcode 0x02; without it that opcode traps as illegal.
//
// Memory handshake: mem_req is held high for the whole access; the access
// completes in the cycle mem_ready is sampled high while mem_req is high.
// A stall that reaches MAX_WAIT wait cycles with no ready ends in TRAP with
// bus_err set.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  opcode_t     opcode,
  input  funct_t      funct,
  input  logic        zero,
  input  logic        mem_ready,
  output ctrl_state_t state,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic        alu_decode,
  output logic        bus_err,
  output logic        illegal
);

  logic in_access;
  logic expired;
  logic timeout;

  assign in_access = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // Counter sits at zero outside accesses, so every access starts from zero.
  assign timeout   = expired && !mem_ready;

  mem_wait_timer u_wait (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_access || mem_ready),
    .count   (in_access && !mem_ready),
    .limit   (8'(MAX_WAIT)),
    .expired (expired)
  );

  // State register plus sticky fault flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      bus_err <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            state <= DECODE;
          end else if (timeout) begin
            state   <= TRAP;
            bus_err <= 1'b1;
          end
        end
        DECODE: begin
          if ((opcode == OP_RTYPE) && is_rtype_funct(funct)) begin
            state <= EXEC_R;
          end else if (is_alu_imm(opcode)) begin
            state <= EXEC_I;
          end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
            state <= MEM_ADDR;
          end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
            state <= BRANCH;
`ifdef ASTRIO_JUMP_EN
          end else if (opcode == OP_J) begin
            state <= JUMP;
`endif
          end else begin
            state   <= TRAP;
            illegal <= 1'b1;
          end
        end
        EXEC_R:   state <= WB_R;
        EXEC_I:   state <= WB_I;
        MEM_ADDR: state <= (opcode == OP_SW) ? MEM_WR : MEM_RD;
        MEM_RD: begin
          if (mem_ready) begin
            state <= WB_MEM;
          end else if (timeout) begin
            state   <= TRAP;
            bus_err <= 1'b1;
          end
        end
        MEM_WR: begin
          if (mem_ready) begin
            state <= FETCH;
          end else if (timeout) begin
            state   <= TRAP;
            bus_err <= 1'b1;
          end
        end
        WB_R, WB_I, WB_MEM, BRANCH: state <= FETCH;
`ifdef ASTRIO_JUMP_EN
        JUMP:     state <= FETCH;
`endif
        TRAP:     state <= TRAP;
        default:  state <= TRAP;
      endcase
    end
  end

  // Per-state datapath controls; strobes are forced low while in reset.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_src     = 2'd0;
    alu_decode = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE:   alu_src_b = 2'd3;
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_decode = 1'b1;
      end
      EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        alu_decode = 1'b1;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      WB_I:     reg_write = 1'b1;
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_decode = 1'b1;
        pc_src     = 2'd1;
        pc_write   = (opcode == OP_BNE) ? !zero : zero;
      end
`ifdef ASTRIO_JUMP_EN
      JUMP: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
      end
`endif
      default: ;
    endcase
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Each instruction pushes its expected
// per-cycle trace (state, strobes, selects) plus the mem_ready/zero stimulus
// onto queues; run() drives and pops them one cycle at a time.
// Honours ASTRIO_JUMP_EN the same way the design does.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  localparam int MAX_WAIT = 15;
  localparam int W = 16;

  // Expected strobe patterns: {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg}
  localparam logic [7:0] S_NONE   = 8'b0000_0000;
  localparam logic [7:0] S_FWAIT  = 8'b1000_0000;
  localparam logic [7:0] S_FDONE  = 8'b1001_1000;
  localparam logic [7:0] S_WB_R   = 8'b0000_0110;
  localparam logic [7:0] S_WB_I   = 8'b0000_0100;
  localparam logic [7:0] S_MEM_RD = 8'b1010_0000;
  localparam logic [7:0] S_MEM_WR = 8'b1110_0000;
  localparam logic [7:0] S_WB_MEM = 8'b0000_0101;
  localparam logic [7:0] S_PCW    = 8'b0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  opcode_t     opcode;
  funct_t      funct;
  logic        zero;
  logic        mem_ready;
  ctrl_state_t state;
  logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, alu_decode, bus_err, illegal;
  logic [1:0]  alu_src_b, pc_src;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  logic         zero_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  multicycle_controller #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .state      (state),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_decode (alu_decode),
    .bus_err    (bus_err),
    .illegal    (illegal)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {state, mem_req, mem_we, iord, ir_write, pc_write, reg_write,
            reg_dst, mem_to_reg, alu_src_b, pc_src};
  endfunction

  // Driver tasks: queue one expected cycle with its stimulus
  task automatic push(input ctrl_state_t st, input logic rdy, input logic z,
                      input logic [7:0] strb, input logic [1:0] asb, input logic [1:0] pcs);
    exp_q.push_back({st, strb, asb, pcs});
    rdy_q.push_back(rdy);
    zero_q.push_back(z);
  endtask

  task automatic fetch_decode(input int waits);
    for (int i = 0; i < waits; i++) push(FETCH, 1'b0, 1'b0, S_FWAIT, 2'd1, 2'd0);
    push(FETCH, 1'b1, 1'b0, S_FDONE, 2'd1, 2'd0);
    push(DECODE, 1'b0, 1'b0, S_NONE, 2'd3, 2'd0);
  endtask

  task automatic instr_r(input funct_t f, input int waits);
    opcode = OP_RTYPE;
    funct  = f;
    fetch_decode(waits);
    push(EXEC_R, 1'b0, 1'b0, S_NONE, 2'd0, 2'd0);
    push(WB_R,   1'b0, 1'b0, S_WB_R, 2'd0, 2'd0);
  endtask

  task automatic instr_i(input opcode_t op, input int waits);
    opcode = op;
    funct  = 6'h3F;
    fetch_decode(waits);
    push(EXEC_I, 1'b0, 1'b0, S_NONE, 2'd2, 2'd0);
    push(WB_I,   1'b0, 1'b0, S_WB_I, 2'd0, 2'd0);
  endtask

  task automatic instr_lw(input int fwaits, input int mwaits);
    opcode = OP_LW;
    fetch_decode(fwaits);
    push(MEM_ADDR, 1'b0, 1'b0, S_NONE, 2'd2, 2'd0);
    for (int i = 0; i < mwaits; i++) push(MEM_RD, 1'b0, 1'b0, S_MEM_RD, 2'd0, 2'd0);
    push(MEM_RD, 1'b1, 1'b0, S_MEM_RD, 2'd0, 2'd0);
    push(WB_MEM, 1'b0, 1'b0, S_WB_MEM, 2'd0, 2'd0);
  endtask

  task automatic instr_sw(input int fwaits, input int mwaits);
    opcode = OP_SW;
    fetch_decode(fwaits);
    push(MEM_ADDR, 1'b0, 1'b0, S_NONE, 2'd2, 2'd0);
    for (int i = 0; i < mwaits; i++) push(MEM_WR, 1'b0, 1'b0, S_MEM_WR, 2'd0, 2'd0);
    push(MEM_WR, 1'b1, 1'b0, S_MEM_WR, 2'd0, 2'd0);
  endtask

  task automatic instr_br(input opcode_t op, input logic z, input logic taken);
    opcode = op;
    fetch_decode(0);
    push(BRANCH, 1'b0, z, taken ? S_PCW : S_NONE, 2'd0, 2'd1);
  endtask

  // Scoreboard: drive one queued cycle per negedge and compare mid-cycle
  task automatic run(input string tag);
    int idx = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      zero      = zero_q.pop_front();
      #1;
      check($sformatf("%s[%0d]", tag, idx), observed(), exp_q.pop_front());
      idx++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check({tag, "_rst_state"}, state, FETCH);
    check({tag, "_rst_strobes"}, {mem_req, mem_we, ir_write, pc_write, reg_write}, 5'b0);
    check({tag, "_rst_flags"}, {bus_err, illegal}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam funct_t R_FN[7] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL, FN_SRL, FN_SLT};
  localparam opcode_t I_OP[4] = '{OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI};

  initial begin
    rst = 1'b1;
    opcode = OP_RTYPE;
    funct = FN_ADD;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("reset_state", state, FETCH);
    check("reset_strobes", {mem_req, mem_we, ir_write, pc_write, reg_write}, 5'b0);
    check("reset_flags", {bus_err, illegal}, 2'b00);
    check("reset_fetch_alu", {alu_src_b, alu_decode}, 3'b010);
    @(negedge clk);
    rst = 1'b0;

    // Directed instruction traces
    instr_r(FN_ADD, 0);        run("add");
    instr_i(OP_ADDI, 0);       run("addi");
    instr_sw(0, 0);            run("sw");
    instr_lw(0, 3);            run("lw_wait3");
    instr_br(OP_BEQ, 1'b1, 1'b1); run("beq_z1");
    instr_br(OP_BNE, 1'b1, 1'b0); run("bne_z1");
    instr_br(OP_BEQ, 1'b0, 1'b0); run("beq_z0");
    instr_br(OP_BNE, 1'b0, 1'b1); run("bne_z0");
    instr_r(FN_SUB, 2);        run("sub_fwait2");
    // Ready arriving exactly at the wait limit still completes
    instr_r(FN_OR, MAX_WAIT);  run("fetch_limit_ok");
    instr_sw(0, MAX_WAIT);     run("sw_limit_ok");
    check("no_fault_flags", {bus_err, illegal}, 2'b00);

    // Randomised mix of legal instructions and wait patterns
    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 3))
        0: instr_r(R_FN[$urandom_range(0, 6)], $urandom_range(0, 3));
        1: instr_i(I_OP[$urandom_range(0, 3)], $urandom_range(0, 3));
        2: instr_lw($urandom_range(0, 2), $urandom_range(0, 4));
        default: instr_sw($urandom_range(0, 2), $urandom_range(0, 4));
      endcase
      run($sformatf("rand%0d", n));
    end

    // Illegal opcode
    opcode = 6'h3F;
    fetch_decode(0);
    for (int i = 0; i < 4; i++) push(TRAP, 1'b1, 1'b1, S_NONE, 2'd0, 2'd0);
    run("illegal_op");
    check("illegal_flags", {bus_err, illegal}, 2'b01);
    do_reset("illegal");

    // Unsupported R-type funct
    opcode = OP_RTYPE;
    funct = 6'h21;
    fetch_decode(0);
    push(TRAP, 1'b1, 1'b0, S_NONE, 2'd0, 2'd0);
    run("bad_funct");
    check("bad_funct_flags", {bus_err, illegal}, 2'b01);
    do_reset("bad_funct");

    // Jump opcode
`ifdef ASTRIO_JUMP_EN
    opcode = OP_J;
    fetch_decode(0);
    push(JUMP, 1'b0, 1'b0, S_PCW, 2'd0, 2'd2);
    push(FETCH, 1'b1, 1'b0, S_FDONE, 2'd1, 2'd0);
    run("jump");
    check("jump_flags", {bus_err, illegal}, 2'b00);
    do_reset("jump");
`else
    opcode = OP_J;
    fetch_decode(0);
    push(TRAP, 1'b1, 1'b0, S_NONE, 2'd0, 2'd0);
    run("jump_trap");
    check("jump_trap_flags", {bus_err, illegal}, 2'b01);
    do_reset("jump_trap");
`endif

    // Fetch stall past the limit: bus error, held in TRAP
    opcode = OP_RTYPE;
    funct = FN_ADD;
    for (int i = 0; i <= MAX_WAIT; i++) push(FETCH, 1'b0, 1'b0, S_FWAIT, 2'd1, 2'd0);
    for (int i = 0; i < 3; i++) push(TRAP, 1'b0, 1'b0, S_NONE, 2'd0, 2'd0);
    push(TRAP, 1'b1, 1'b0, S_NONE, 2'd0, 2'd0);
    run("fetch_timeout");
    check("timeout_flags", {bus_err, illegal}, 2'b10);
    do_reset("timeout");

    // Reset in the middle of a stalled store
    opcode = OP_SW;
    fetch_decode(0);
    push(MEM_ADDR, 1'b0, 1'b0, S_NONE, 2'd2, 2'd0);
    push(MEM_WR, 1'b0, 1'b0, S_MEM_WR, 2'd0, 2'd0);
    push(MEM_WR, 1'b0, 1'b0, S_MEM_WR, 2'd0, 2'd0);
    run("sw_stall");
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("midwr_mem_we", mem_we, 1'b0);
    check("midwr_mem_req", mem_req, 1'b0);
    check("midwr_state", state, FETCH);
    @(negedge clk);
    rst = 1'b0;
    instr_sw(0, 1);
    run("sw_after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
